acc_act_writeback: RTL and testbench
====================================

Name: acc_act_writeback

Overview:
Parametrised post-processing and writeback stage for the accelerator datapath. It accepts a stream of fp16 conv/BN results with a ready/valid handshake and groups them into LANES-wide batches. Each batch gets an activation: bypass, ReLU, or LUT lookup through a single time-shared LUT SRAM port. Results are written sequentially into the output SRAM, and the stage raises a frame-done pulse for the ICB status register.

Parameters:
LANES, 4, samples per batch (1..16)
ADDR_W, 13, output SRAM address width
LUT_AW, 12, LUT SRAM address width (≤15)
OUT_BASE, 0, first output SRAM address of a frame

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle frame start pulse; honoured only in IDLE
frame_len  in  ADDR_W+1  samples in frame, sampled on start
act_mode  in  2  0 bypass, 1 ReLU, 2 LUT, 3 treated as bypass; sampled on start
din_valid  in  1  input sample valid
din_ready  out  1  stage can accept a sample
din  in  16  fp16 sample
lut_rd_en  out  1  LUT read strobe
lut_rd_addr  out  LUT_AW  LUT address
lut_rd_data  in  32  {neg_result, pos_result}; valid one cycle after lut_rd_en
ofm_wr_en  out  1  output SRAM write strobe
ofm_wr_addr  out  ADDR_W  output SRAM address
ofm_wr_data  out  32  output SRAM data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0, write address OUT_BASE.
- Reset mid-frame aborts the frame, with no done pulse and no further writes.
- States: IDLE, COLLECT, LOOKUP, WRITE, FIN.
- IDLE:
  - start with frame_len>0 -> COLLECT, wr_addr=OUT_BASE, remaining=frame_len.
  - start with frame_len==0 -> FIN.
  - start while not IDLE is ignored.
- COLLECT:
  - din_ready=1. A transfer occurs when din_valid&din_ready; the sample goes into lane slot lane_cnt and remaining decrements.
  - Leave COLLECT when lane_cnt reaches LANES, or when remaining hits 0 (partial batch, n_valid = lane_cnt).
  - Exit goes to LOOKUP if mode==2, else WRITE.
  - din_ready deasserts combinationally in the cycle after the accepting transfer that completes the batch.
- LOOKUP (mode 2 only):
  - Cycle k (k=0..n_valid-1): lut_rd_en=1, lut_rd_addr=slot[k][14:(15-LUT_AW)], i.e. magnitude bits, sign excluded.
  - Cycle k+1: result[k] = slot[k][15] ? lut_rd_data[31:16] : lut_rd_data[15:0].
  - Duration n_valid+1 cycles, then WRITE.
  - Invalid lanes are never read.
- Activation rules:
  - Bypass: result = slot.
  - ReLU: result = 16'h0000 if sign bit set, including -0; else slot.
- WRITE:
  - One ofm_wr_en pulse per output word, consecutive cycles.
  - Each write: ofm_wr_addr = wr_addr, then wr_addr increments and wraps modulo 2^ADDR_W.
  - Default data: ofm_wr_data = {16'h0000, result[k]}, k=0..n_valid-1.
  - Afterwards: if remaining>0 -> COLLECT with lane_cnt=0, else FIN.
- FIN: done=1 for exactly one cycle -> IDLE.
- Throughput: a full batch in bypass mode costs LANES (collect) + LANES (write) cycles. No overlap between collect and write is required.
- din is ignored whenever din_ready=0. Simultaneous din_valid with start in IDLE is not accepted.

Optional Feature:
ACT_PACK2_EN:
- Defined: WRITE packs lane pairs, ofm_wr_data = {result[2m+1], result[2m]}, giving ceil(n_valid/2) writes per batch. An odd trailing lane is written as {16'h0000, result[last]}. LANES must be even, enforced by an elaboration-time check.
- Undefined: one 16-bit result per 32-bit word, as above.

Test Plan:
- Bypass, LANES=4, frame_len=8, din=16'h3C00..16'h3C07 -> 8 writes, addr 0..7, data {0,din}; done one cycle after last write; busy falls with done.
- ReLU, frame_len=4, din={16'hBC00,16'h3C00,16'h8000,16'h4000} -> data {0x0000,0x3C00,0x0000,0x4000}.
- LUT mode, LUT word at 12'h780 = 32'hAAAA_5555; din=16'h3C00 -> pos result 16'h5555; din=16'hBC00 -> 16'hAAAA; lut_rd_en high exactly 4 cycles per full batch.
- Partial batch, frame_len=6, LANES=4 -> writes addr 0..5, second batch issues 2 LUT reads; din_ready low after 6th transfer; din_valid held high without effect.
- Edge cases: frame_len=0 gives done one cycle after start with no writes; start while busy is ignored; rst asserted mid-WRITE gives immediate zero outputs and no done; OUT_BASE=8190 with frame_len=4 wraps addresses to 8190,8191,0,1.
- ACT_PACK2_EN, frame_len=3 bypass, din=A,B,C -> 2 writes: {B,A}, {0,C}.

Source files
------------

// File: rtl/acc_act_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_act_writeback_if
//  Description : Bus bundle for the activation/writeback stage. It carries the
//                fp16 sample stream (ready/valid), the LUT SRAM read port and
//                the output SRAM write port.
//                  master : the writeback stage
//                  slave  : the surrounding datapath and SRAM models
//  Ports       : din_valid/din_ready/din       sample stream
//                lut_rd_en/lut_rd_addr/lut_rd_data  LUT SRAM read port
//                ofm_wr_en/ofm_wr_addr/ofm_wr_data  output SRAM write port
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_act_writeback_if #(
    parameter int ADDR_W = 13,
    parameter int LUT_AW = 12
);
    logic              din_valid;
    logic              din_ready;
    logic [15:0]       din;
    logic              lut_rd_en;
    logic [LUT_AW-1:0] lut_rd_addr;
    logic [31:0]       lut_rd_data;
    logic              ofm_wr_en;
    logic [ADDR_W-1:0] ofm_wr_addr;
    logic [31:0]       ofm_wr_data;

    modport master (
        input  din_valid, din, lut_rd_data,
        output din_ready, lut_rd_en, lut_rd_addr, ofm_wr_en, ofm_wr_addr, ofm_wr_data
    );

    modport slave (
        output din_valid, din, lut_rd_data,
        input  din_ready, lut_rd_en, lut_rd_addr, ofm_wr_en, ofm_wr_addr, ofm_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/acc_act_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : acc_act_writeback
//  Description : Post-processing / writeback stage. Collects fp16 samples into
//                LANES-wide batches, applies bypass, ReLU or LUT activation
//                (one time-shared LUT read port), and writes the results
//                sequentially into the output SRAM starting at OUT_BASE.
//                Optional build macro ACT_PACK2_EN packs two 16-bit results
//                per 32-bit output word (LANES must then be even).
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                start          frame start pulse (honoured in IDLE only)
//                frame_len      samples per frame, sampled on start
//                act_mode       0 bypass, 1 ReLU, 2 LUT, 3 bypass
//                busy, done     status: not idle / end-of-frame pulse
//                bus            stream, LUT and output SRAM ports (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_act_writeback #(
    parameter int LANES    = 4,
    parameter int ADDR_W   = 13,
    parameter int LUT_AW   = 12,
    parameter int OUT_BASE = 0
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire  [ADDR_W:0]     frame_len,
    input  wire  [1:0]          act_mode,
    output logic                busy,
    output logic                done,
    acc_act_writeback_if.master bus
);

    localparam int c_cnt_w = $clog2(LANES + 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_collect = 3'd1;
    localparam logic [2:0] c_st_lookup  = 3'd2;
    localparam logic [2:0] c_st_write   = 3'd3;
    localparam logic [2:0] c_st_fin     = 3'd4;

    localparam logic [ADDR_W-1:0]  c_base      = OUT_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W:0]    c_rem_one   = 1;
    localparam logic [c_cnt_w-1:0] c_one_cnt   = 1;
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(LANES - 1);

`ifdef ACT_PACK2_EN
    generate
        if ((LANES % 2) != 0) begin : g_lanes_odd
            $error("acc_act_writeback: ACT_PACK2_EN requires an even LANES");
        end
    endgenerate
    localparam logic [c_cnt_w-1:0] c_step = 2;
`else
    localparam logic [c_cnt_w-1:0] c_step = 1;
`endif

    logic [2:0]         r_state;
    logic [1:0]         r_mode;
    logic [ADDR_W:0]    r_remaining;
    logic [c_cnt_w-1:0] r_lane_cnt;
    logic [c_cnt_w-1:0] r_n_valid;
    logic [c_cnt_w-1:0] r_idx;       // LUT issue index in LOOKUP, word index in WRITE
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [15:0]        r_slot [LANES];

    logic [15:0]        w_slot_cur;
    logic               w_prv_neg;
    logic               w_last_word;

    // ReLU only; LUT results already overwrite their slots during LOOKUP.
    function automatic logic [15:0] act_fn(input logic [1:0] mode, input logic [15:0] v);
        act_fn = (mode == 2'd1 && v[15]) ? 16'h0000 : v;
    endfunction

    // Slot selection. The previous slot's sign picks the half of the LUT word
    // that returns one cycle after that slot's read was issued.
    always_comb begin
        w_slot_cur = '0;
        w_prv_neg  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (c_cnt_w'(i) == r_idx)
                w_slot_cur = r_slot[i];
            if (c_cnt_w'(i) + c_one_cnt == r_idx)
                w_prv_neg = r_slot[i][15];
        end
    end

`ifdef ACT_PACK2_EN
    logic [15:0] w_slot_nxt;
    logic        w_pair;

    always_comb begin
        w_slot_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (c_cnt_w'(i) == r_idx + c_one_cnt)
                w_slot_nxt = r_slot[i];
        end
    end

    assign w_pair = (r_idx + c_one_cnt) < r_n_valid;
`endif

    assign w_last_word = (r_idx + c_step) >= r_n_valid;

    // Outputs are decoded from state so an asynchronous reset clears them at once.
    assign bus.din_ready   = (r_state == c_st_collect);
    assign bus.lut_rd_en   = (r_state == c_st_lookup) && (r_idx != r_n_valid);
    assign bus.lut_rd_addr = bus.lut_rd_en ? w_slot_cur[14 -: LUT_AW] : '0;
    assign bus.ofm_wr_en   = (r_state == c_st_write);
    assign bus.ofm_wr_addr = bus.ofm_wr_en ? r_wr_addr : '0;
    assign busy            = (r_state != c_st_idle);
    assign done            = (r_state == c_st_fin);

    always_comb begin
        bus.ofm_wr_data = '0;
        if (bus.ofm_wr_en) begin
`ifdef ACT_PACK2_EN
            if (w_pair)
                bus.ofm_wr_data = {act_fn(r_mode, w_slot_nxt), act_fn(r_mode, w_slot_cur)};
            else
                bus.ofm_wr_data = {16'h0000, act_fn(r_mode, w_slot_cur)};
`else
            bus.ofm_wr_data = {16'h0000, act_fn(r_mode, w_slot_cur)};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_mode      <= '0;
            r_remaining <= '0;
            r_lane_cnt  <= '0;
            r_n_valid   <= '0;
            r_idx       <= '0;
            r_wr_addr   <= c_base;
            for (int i = 0; i < LANES; i++)
                r_slot[i] <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mode     <= act_mode;
                        r_lane_cnt <= '0;
                        r_idx      <= '0;
                        if (frame_len != '0) begin
                            r_remaining <= frame_len;
                            r_wr_addr   <= c_base;
                            r_state     <= c_st_collect;
                        end else begin
                            r_state <= c_st_fin;
                        end
                    end
                end

                c_st_collect: begin
                    if (bus.din_valid) begin
                        for (int i = 0; i < LANES; i++)
                            if (c_cnt_w'(i) == r_lane_cnt)
                                r_slot[i] <= bus.din;
                        r_lane_cnt  <= r_lane_cnt + c_one_cnt;
                        r_remaining <= r_remaining - 1'b1;
                        // Batch closes on the accepting edge: full, or frame exhausted.
                        if (r_lane_cnt == c_last_lane || r_remaining == c_rem_one) begin
                            r_n_valid <= r_lane_cnt + c_one_cnt;
                            r_idx     <= '0;
                            r_state   <= (r_mode == 2'd2) ? c_st_lookup : c_st_write;
                        end
                    end
                end

                c_st_lookup: begin
                    // Data for read idx-1 is on the bus now; it replaces that slot.
                    if (r_idx != '0) begin
                        for (int i = 0; i < LANES; i++)
                            if (c_cnt_w'(i) + c_one_cnt == r_idx)
                                r_slot[i] <= w_prv_neg ? bus.lut_rd_data[31:16]
                                                       : bus.lut_rd_data[15:0];
                    end
                    if (r_idx == r_n_valid) begin
                        r_idx   <= '0;
                        r_state <= c_st_write;
                    end else begin
                        r_idx <= r_idx + c_one_cnt;
                    end
                end

                c_st_write: begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                    if (w_last_word) begin
                        r_idx      <= '0;
                        r_lane_cnt <= '0;
                        r_state    <= (r_remaining != '0) ? c_st_collect : c_st_fin;
                    end else begin
                        r_idx <= r_idx + c_step;
                    end
                end

                c_st_fin: r_state <= c_st_idle;

                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_act_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_act_writeback
//  Description : Self-checking bench for acc_act_writeback. Two instances share
//                all stimulus; the second uses OUT_BASE=8190 so every frame
//                also exercises output address wrap. Honours ACT_PACK2_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_act_writeback;

    localparam int LANES     = 4;
    localparam int ADDR_W    = 13;
    localparam int LUT_AW    = 12;
    localparam int WRAP_BASE = 8190;

    typedef struct {
        int          mode;
        int          len;
        bit          hold;
        logic [15:0] din [8];
        logic [15:0] res [8];
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   frame_len;
    logic [1:0]        act_mode;
    logic              busy, done, busy_w, done_w;

    acc_act_writeback_if #(.ADDR_W(ADDR_W), .LUT_AW(LUT_AW)) bus ();
    acc_act_writeback_if #(.ADDR_W(ADDR_W), .LUT_AW(LUT_AW)) bus_w ();

    acc_act_writeback #(.LANES(LANES), .ADDR_W(ADDR_W), .LUT_AW(LUT_AW), .OUT_BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .act_mode(act_mode),
        .busy(busy), .done(done), .bus(bus)
    );

    acc_act_writeback #(.LANES(LANES), .ADDR_W(ADDR_W), .LUT_AW(LUT_AW), .OUT_BASE(WRAP_BASE)) dut_w (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .act_mode(act_mode),
        .busy(busy_w), .done(done_w), .bus(bus_w)
    );

    always #5 clk = ~clk;

    assign bus_w.din_valid   = bus.din_valid;
    assign bus_w.din         = bus.din;
    assign bus_w.lut_rd_data = bus.lut_rd_data;

    logic [31:0] lut_mem [4096];
    always @(posedge clk)
        if (bus.lut_rd_en) bus.lut_rd_data <= lut_mem[bus.lut_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [44:0] wq[$], wq_w[$], exp0[$], exp_w[$];
    logic [15:0] src_q[$], res_q[$];
    int lut_reads = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
    int n_cmp = 0, n_bad = 0;
    vec_t tbl [6];

    always @(negedge clk) begin
        if (bus.ofm_wr_en) begin
            wq.push_back({bus.ofm_wr_addr, bus.ofm_wr_data});
            last_wr_cyc = cyc;
        end
        if (bus_w.ofm_wr_en) wq_w.push_back({bus_w.ofm_wr_addr, bus_w.ofm_wr_data});
        if (bus.lut_rd_en) lut_reads++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Activation from the rules: ReLU zeroes any negative (incl. -0), LUT picks
    // the half of the word addressed by the magnitude bits according to sign.
    function automatic logic [15:0] ref_act(input int mode, input logic [15:0] s);
        logic [31:0] e;
        e = lut_mem[s[14 -: LUT_AW]];
        case (mode)
            1:       return s[15] ? 16'h0000 : s;
            2:       return s[15] ? e[31:16] : e[15:0];
            default: return s;
        endcase
    endfunction

    task automatic push_word(input logic [31:0] w, inout int a0, inout int aw);
        exp0.push_back({13'(a0), w});
        exp_w.push_back({13'(aw), w});
        a0 = (a0 + 1) % 8192;
        aw = (aw + 1) % 8192;
    endtask

    // Expected write list from the per-sample results, batch by batch.
    task automatic build_exp();
        int a0, aw, n;
        a0 = 0;
        aw = WRAP_BASE;
        exp0.delete();
        exp_w.delete();
        for (int b = 0; b < res_q.size(); b += LANES) begin
            n = res_q.size() - b;
            if (n > LANES) n = LANES;
`ifdef ACT_PACK2_EN
            for (int k = 0; k < n; k += 2)
                push_word((k + 1 < n) ? {res_q[b+k+1], res_q[b+k]} : {16'h0000, res_q[b+k]}, a0, aw);
`else
            for (int k = 0; k < n; k++)
                push_word({16'h0000, res_q[b+k]}, a0, aw);
`endif
        end
    endtask

    task automatic send_sample(input logic [15:0] v, output bit ok);
        int b;
        b = 0;
        bus.din_valid = 1'b1;
        bus.din = v;
        do begin
            @(negedge clk);
            ok = bus.din_ready;
            @(posedge clk);
            #1;
            b++;
        end while (!ok && b < 200);
    endtask

    task automatic run_frame(input int mode, input int len, input bit gaps, input bit hold, input bit poke);
        int s_cyc, d0, b;
        bit ok;
        wq.delete();
        wq_w.delete();
        lut_reads = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 14'(len);
        act_mode = 2'(mode);
        @(negedge clk);
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        frame_len = 14'($urandom);  // must have been latched already
        act_mode = 2'($urandom);
        for (int i = 0; i < len; i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    bus.din_valid = 1'b0;
                    bus.din = 16'($urandom);
                    @(posedge clk); #1;
                end
            if (poke && i == 2) begin
                start = 1'b1;
                frame_len = 14'd2;
                act_mode = 2'd1;
            end
            send_sample(src_q[i], ok);
            start = 1'b0;
            chk($sformatf("din handshake %0d", i), ok, 1);
            if (!(hold && i == len - 1)) bus.din_valid = 1'b0;
        end
        if (len > 0) begin
            @(negedge clk);
            chk("din_ready after last transfer", bus.din_ready, 0);
        end
        b = 0;
        do begin
            @(negedge clk); #1;
            b++;
        end while (done_cnt == d0 && b < 300);
        chk("done seen", done_cnt - d0, 1);
        chk("busy during done", busy, 1);
        @(negedge clk); #1;
        chk("busy after done", busy, 0);
        chk("done width", done, 0);
        bus.din_valid = 1'b0;
        build_exp();
        chk("write count", wq.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < wq.size(); i++)
            chk($sformatf("write %0d", i), wq[i], exp0[i]);
        chk("wrap write count", wq_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq_w.size(); i++)
            chk($sformatf("wrap write %0d", i), wq_w[i], exp_w[i]);
        chk("lut reads", lut_reads, (mode == 2) ? len : 0);
        if (len == 0)
            chk("done latency", done_cyc, s_cyc + 1);
        else
            chk("done after last write", done_cyc, last_wr_cyc + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d0, mode, len;
        bit ok;
        rst = 1'b1;
        start = 1'b0;
        frame_len = '0;
        act_mode = '0;
        bus.din_valid = 1'b0;
        bus.din = '0;
        for (int i = 0; i < 4096; i++) lut_mem[i] = $urandom;
        lut_mem[12'h780] = 32'hAAAA_5555;

        for (int v = 0; v < 6; v++)
            for (int i = 0; i < 8; i++) begin
                tbl[v].din[i] = '0;
                tbl[v].res[i] = '0;
            end
        tbl[0].mode = 0; tbl[0].len = 8; tbl[0].hold = 0;
        for (int i = 0; i < 8; i++) begin
            tbl[0].din[i] = 16'h3C00 + 16'(i);
            tbl[0].res[i] = 16'h3C00 + 16'(i);
        end
        tbl[1].mode = 1; tbl[1].len = 4; tbl[1].hold = 0;
        tbl[1].din = '{16'hBC00, 16'h3C00, 16'h8000, 16'h4000, 0, 0, 0, 0};
        tbl[1].res = '{16'h0000, 16'h3C00, 16'h0000, 16'h4000, 0, 0, 0, 0};
        tbl[2].mode = 2; tbl[2].len = 4; tbl[2].hold = 0;
        tbl[2].din = '{16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00, 0, 0, 0, 0};
        tbl[2].res = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 0, 0, 0, 0};
        tbl[3].mode = 2; tbl[3].len = 6; tbl[3].hold = 1;
        tbl[3].din = '{16'h3C00, 16'hBC00, 16'hBC00, 16'h3C00, 16'h3C00, 16'hBC00, 0, 0};
        tbl[3].res = '{16'h5555, 16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 0, 0};
        tbl[4].mode = 0; tbl[4].len = 3; tbl[4].hold = 0;
        tbl[4].din = '{16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0, 0};
        tbl[4].res = '{16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0, 0};
        tbl[5].mode = 3; tbl[5].len = 2; tbl[5].hold = 1;
        tbl[5].din = '{16'h8001, 16'h7FFF, 0, 0, 0, 0, 0, 0};
        tbl[5].res = '{16'h8001, 16'h7FFF, 0, 0, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset din_ready", bus.din_ready, 0);
        chk("reset lut_rd_en", bus.lut_rd_en, 0);
        chk("reset lut_rd_addr", bus.lut_rd_addr, 0);
        chk("reset ofm_wr_en", bus.ofm_wr_en, 0);
        chk("reset ofm_wr_addr", bus.ofm_wr_addr, 0);
        chk("reset ofm_wr_data", bus.ofm_wr_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            src_q.delete();
            res_q.delete();
            for (int i = 0; i < tbl[v].len; i++) begin
                src_q.push_back(tbl[v].din[i]);
                res_q.push_back(tbl[v].res[i]);
            end
            run_frame(tbl[v].mode, tbl[v].len, 1'b0, tbl[v].hold, 1'b0);
        end

        // Empty frame: done right after start, no writes
        src_q.delete();
        res_q.delete();
        run_frame(0, 0, 1'b0, 1'b0, 1'b0);

        // Start pulses while busy must not disturb the running frame
        src_q.delete();
        res_q.delete();
        for (int i = 0; i < 8; i++) begin
            src_q.push_back(16'($urandom));
            res_q.push_back(ref_act(0, src_q[i]));
        end
        run_frame(0, 8, 1'b0, 1'b0, 1'b1);

        // Reset during WRITE: outputs clear at once, no done, no more writes
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 14'd4;
        act_mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_sample(16'($urandom), ok);
            chk($sformatf("reset-test handshake %0d", i), ok, 1);
        end
        bus.din_valid = 1'b0;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!bus.ofm_wr_en && b < 50);
        chk("write before reset", bus.ofm_wr_en, 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid-reset ofm_wr_en", bus.ofm_wr_en, 0);
        chk("mid-reset ofm_wr_data", bus.ofm_wr_data, 0);
        chk("mid-reset ofm_wr_addr", bus.ofm_wr_addr, 0);
        chk("mid-reset busy", busy, 0);
        chk("mid-reset done", done, 0);
        wq.delete();
        wq_w.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("writes after reset", wq.size(), 0);
        chk("done after reset", done_cnt - d0, 0);

        // Randomised frames against the reference model
        for (int f = 0; f < 25; f++) begin
            mode = $urandom_range(0, 3);
            len = $urandom_range(1, 13);
            src_q.delete();
            res_q.delete();
            for (int i = 0; i < len; i++) begin
                src_q.push_back(16'($urandom));
                res_q.push_back(ref_act(mode, src_q[i]));
            end
            run_frame(mode, len, 1'b1, f[0], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
